// File: rtl/sqrt_single_cycle.sv
// rtl/sqrt_single_cycle.sv - single-cycle unsigned integer square root, floor(sqrt(arg))
//
// sqrt_stage_cell: one restoring square-root step.
//   rem_in   - partial remainder from the previous step (ROOT_WIDTH+2 bits)
//   root_in  - partial root from the previous step (ROOT_WIDTH bits)
//   arg_pair - next two radicand bits, taken MSB pair first
//   rem_out  - updated remainder
//   root_out - partial root with the new bit shifted in
//
// sqrt_single_cycle: a combinational chain of DATA_WIDTH/2 cells followed by one
// output register.
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears res and res_vld
//   arg_vld  - arg is valid this cycle
//   arg      - unsigned radicand
//   res_vld  - one-cycle pulse per accepted arg, one cycle after acceptance
//   res      - floor(sqrt(arg)) zero-extended, held while arg_vld is low

module sqrt_stage_cell #(
  parameter int ROOT_WIDTH = 4
) (
  input  logic [ROOT_WIDTH+1:0] rem_in,
  input  logic [ROOT_WIDTH-1:0] root_in,
  input  logic [1:0]            arg_pair,
  output logic [ROOT_WIDTH+1:0] rem_out,
  output logic [ROOT_WIDTH-1:0] root_out
);

  localparam int REM_WIDTH = ROOT_WIDTH + 2;

  logic [REM_WIDTH-1:0] shifted;
  logic [REM_WIDTH-1:0] trial;
  logic [REM_WIDTH:0]   diff;
  logic                 ge;
  logic [ROOT_WIDTH:0]  root_next;
  logic                 unused_bits;

  // The remainder never exceeds twice the partial root, so the two bits shifted
  // out of the top are always zero and can be dropped.
  assign shifted   = {rem_in[REM_WIDTH-3:0], arg_pair};
  assign trial     = {root_in, 2'b01};
  // One extra bit on the subtraction acts as the borrow / sign flag.
  assign diff      = {1'b0, shifted} - {1'b0, trial};
  assign ge        = ~diff[REM_WIDTH];
  assign rem_out   = ge ? diff[REM_WIDTH-1:0] : shifted;
  // The partial root has fewer significant bits than ROOT_WIDTH until the last
  // stage, so the bit shifted out of the top is always zero.
  assign root_next = {root_in, ge};
  assign root_out  = root_next[ROOT_WIDTH-1:0];

  assign unused_bits = ^{rem_in[REM_WIDTH-1:REM_WIDTH-2], root_next[ROOT_WIDTH]};

endmodule

module sqrt_single_cycle #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arg_vld,
  input  logic [DATA_WIDTH-1:0] arg,
  output logic                  res_vld,
  output logic [DATA_WIDTH-1:0] res
);

  localparam int HALF_WIDTH = DATA_WIDTH / 2;
  localparam int REM_WIDTH  = HALF_WIDTH + 2;

  logic [HALF_WIDTH-1:0] root_final;
  logic                  unused_rem;

  // Each stage keeps its own signals so the chain links stage to stage through
  // the generate hierarchy rather than through one shared array.
  for (genvar k = 0; k < HALF_WIDTH; k++) begin : g_stage
    logic [REM_WIDTH-1:0]  rem_in;
    logic [REM_WIDTH-1:0]  rem_o;
    logic [HALF_WIDTH-1:0] root_in;
    logic [HALF_WIDTH-1:0] root_o;

    if (k == 0) begin : g_first
      assign rem_in  = '0;
      assign root_in = '0;
    end else begin : g_next
      assign rem_in  = g_stage[k-1].rem_o;
      assign root_in = g_stage[k-1].root_o;
    end

    sqrt_stage_cell #(
      .ROOT_WIDTH(HALF_WIDTH)
    ) u_cell (
      .rem_in  (rem_in),
      .root_in (root_in),
      .arg_pair(arg[DATA_WIDTH-1-2*k -: 2]),
      .rem_out (rem_o),
      .root_out(root_o)
    );
  end

  assign root_final = g_stage[HALF_WIDTH-1].root_o;
  // The final remainder is not needed for a floor root.
  assign unused_rem = ^g_stage[HALF_WIDTH-1].rem_o;

  // res only loads on an accepted arg, so a garbage arg while idle never
  // reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      res_vld <= arg_vld;
      if (arg_vld) begin
        res <= {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, root_final};
      end
    end
  end

endmodule

// File: tb/tb_sqrt_single_cycle.sv
// tb/tb_sqrt_single_cycle.sv - self-checking bench for sqrt_single_cycle
module tb_sqrt_single_cycle;

  logic        clk;
  logic        rst_n;
  logic        arg_vld;
  logic [7:0]  arg;
  logic        res_vld;
  logic [7:0]  res;
  logic        arg_vld16;
  logic [15:0] arg16;
  logic        res_vld16;
  logic [15:0] res16;

  int checks;
  int failures;

  typedef struct {
    int arg;
    int res;
  } vec_t;

  vec_t pulse_vecs[6];
  vec_t b2b_vecs[5];
  vec_t wide_vecs[4];

  sqrt_single_cycle #(.DATA_WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arg_vld(arg_vld),
    .arg    (arg),
    .res_vld(res_vld),
    .res    (res)
  );

  sqrt_single_cycle #(.DATA_WIDTH(16)) dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .arg_vld(arg_vld16),
    .arg    (arg16),
    .res_vld(res_vld16),
    .res    (res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_sqrt(input int a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_res;
    int vld_sent;
    int vld_seen;
    int a;
    int exp16;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    arg_vld   = 1'b0;
    arg       = '0;
    arg_vld16 = 1'b0;
    arg16     = '0;

    pulse_vecs[0] = '{3, 1};
    pulse_vecs[1] = '{0, 0};
    pulse_vecs[2] = '{1, 1};
    pulse_vecs[3] = '{4, 2};
    pulse_vecs[4] = '{16, 4};
    pulse_vecs[5] = '{255, 15};

    b2b_vecs[0] = '{15, 3};
    b2b_vecs[1] = '{16, 4};
    b2b_vecs[2] = '{17, 4};
    b2b_vecs[3] = '{224, 14};
    b2b_vecs[4] = '{225, 15};

    wide_vecs[0] = '{65535, 255};
    wide_vecs[1] = '{40000, 200};
    wide_vecs[2] = '{39999, 199};
    wide_vecs[3] = '{0, 0};

    // Asynchronous reset with no clock edge needed.
    #2 rst_n = 1'b0;
    #1;
    check("reset_res_vld", int'(res_vld), 0);
    check("reset_res", int'(res), 0);
    check("reset_res_vld16", int'(res_vld16), 0);
    check("reset_res16", int'(res16), 0);
    tick;
    tick;
    @(negedge clk) rst_n = 1'b1;
    tick;
    check("post_reset_res_vld", int'(res_vld), 0);

    // Single pulses: result one cycle later, then valid drops and res holds.
    for (int i = 0; i < 6; i++) begin
      arg     = 8'(pulse_vecs[i].arg);
      arg_vld = 1'b1;
      tick;
      check($sformatf("pulse_vld arg=%0d", pulse_vecs[i].arg), int'(res_vld), 1);
      check($sformatf("pulse_res arg=%0d", pulse_vecs[i].arg), int'(res), pulse_vecs[i].res);
      arg_vld = 1'b0;
      arg     = 8'($urandom);
      tick;
      check($sformatf("pulse_drop arg=%0d", pulse_vecs[i].arg), int'(res_vld), 0);
      check($sformatf("pulse_hold arg=%0d", pulse_vecs[i].arg), int'(res), pulse_vecs[i].res);
    end

    // Back-to-back valids.
    for (int i = 0; i < 5; i++) begin
      arg     = 8'(b2b_vecs[i].arg);
      arg_vld = 1'b1;
      tick;
      check($sformatf("b2b_vld arg=%0d", b2b_vecs[i].arg), int'(res_vld), 1);
      check($sformatf("b2b_res arg=%0d", b2b_vecs[i].arg), int'(res), b2b_vecs[i].res);
    end
    arg_vld = 1'b0;
    tick;
    check("b2b_end_vld", int'(res_vld), 0);

    // Exhaustive sweep with random idle gaps carrying random arg values.
    exp_res  = 15;
    vld_sent = 0;
    vld_seen = 0;
    for (int v = 0; v < 256; v++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        arg_vld = 1'b0;
        arg     = 8'($urandom);
        tick;
        if (res_vld) vld_seen++;
        check("sweep_idle_vld", int'(res_vld), 0);
        check("sweep_idle_hold", int'(res), exp_res);
      end
      arg_vld = 1'b1;
      arg     = 8'(v);
      vld_sent++;
      exp_res = ref_sqrt(v);
      tick;
      if (res_vld) vld_seen++;
      check($sformatf("sweep_res arg=%0d", v), int'(res), exp_res);
    end
    arg_vld = 1'b0;
    tick;
    if (res_vld) vld_seen++;
    check("sweep_vld_count", vld_seen, vld_sent);

    // Asynchronous reset between edges while a result is valid.
    arg     = 8'd200;
    arg_vld = 1'b1;
    tick;
    check("mid_reset_pre_vld", int'(res_vld), 1);
    check("mid_reset_pre_res", int'(res), 14);
    #2 rst_n = 1'b0;
    arg = 8'd255;
    #1;
    check("mid_reset_vld", int'(res_vld), 0);
    check("mid_reset_res", int'(res), 0);
    tick;
    tick;
    check("reset_ignores_vld", int'(res_vld), 0);
    check("reset_ignores_res", int'(res), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    arg_vld = 1'b0;
    tick;
    check("release_idle_vld", int'(res_vld), 0);
    arg     = 8'd100;
    arg_vld = 1'b1;
    tick;
    check("release_100_vld", int'(res_vld), 1);
    check("release_100_res", int'(res), 10);
    arg_vld = 1'b0;

    // Wide instance: table then random traffic against the reference model.
    for (int i = 0; i < 4; i++) begin
      arg16     = 16'(wide_vecs[i].arg);
      arg_vld16 = 1'b1;
      tick;
      check($sformatf("w16_vld arg=%0d", wide_vecs[i].arg), int'(res_vld16), 1);
      check($sformatf("w16_res arg=%0d", wide_vecs[i].arg), int'(res16), wide_vecs[i].res);
      arg_vld16 = 1'b0;
      tick;
      check($sformatf("w16_drop arg=%0d", wide_vecs[i].arg), int'(res_vld16), 0);
    end
    exp16 = 0;
    for (int i = 0; i < 300; i++) begin
      a         = int'($urandom_range(0, 65535));
      arg16     = 16'(a);
      arg_vld16 = 1'($urandom_range(0, 1));
      if (arg_vld16) exp16 = ref_sqrt(a);
      tick;
      check("w16_rand_vld", int'(res_vld16), int'(arg_vld16));
      check($sformatf("w16_rand_res arg=%0d", a), int'(res16), exp16);
    end
    arg_vld16 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
